// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, sends start, 8 data bits,
// odd parity and stop on device-generated clock edges, then checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);
  localparam int TO_W  = ($clog2(TIMEOUT_CYCLES + 1) > 20) ? $clog2(TIMEOUT_CYCLES + 1) : 20;
  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_MAX   = '1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             clk_s, data_s, fe;
  logic [9:0]       frame;
  logic [TO_W-1:0]  to_inc;

  // Stage [2] of the clock synchronizer is edge-detect history only.
  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fe     = clk_sync_q[2] & ~clk_sync_q[1];
  assign frame  = {1'b1, parity_q, data_q};
  assign to_inc = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    data_d      = data_q;
    parity_d    = parity_q;
    bit_idx_d   = bit_idx_q;
    inh_cnt_d   = inh_cnt_q;
    to_cnt_d    = to_cnt_q;
    data_oe_d   = data_oe_q;
    done_d      = 1'b0;
    error_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bit_idx_d = '0;
        inh_cnt_d = '0;
        to_cnt_d  = '0;
        if (tx_valid) begin
          data_d   = tx_data;
          parity_d = ~^tx_data;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          state_d   = ST_START;
          data_oe_d = 1'b1;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      ST_START: begin
        state_d   = ST_SEND;
        to_cnt_d  = '0;
        bit_idx_d = '0;
      end
      ST_SEND: begin
        if (fe) begin
          to_cnt_d  = '0;
          data_oe_d = ~frame[bit_idx_q];
          if (bit_idx_q == 4'd9) state_d = ST_ACK;
          else                   bit_idx_d = bit_idx_q + 4'd1;
        end else begin
          to_cnt_d = to_inc;
          if (to_inc >= TO_LIMIT) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_ACK: begin
        if (fe) begin
          to_cnt_d = '0;
          if (data_s) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_IDLE;
          end
        end else begin
          to_cnt_d = to_inc;
          if (to_inc >= TO_LIMIT) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (fe) begin
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_inc;
          if (to_inc >= TO_LIMIT) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line drivers are registered from the next state so they switch with it, glitch-free.
    if (state_d == ST_IDLE) data_oe_d = 1'b0;
    clk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_START);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      data_q      <= '0;
      parity_q    <= 1'b0;
      bit_idx_q   <= '0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      data_q      <= data_d;
      parity_q    <= parity_d;
      bit_idx_q   <= bit_idx_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign tx_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign error       = error_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on an open-drain bus, with a queue of
// expected transfer outcomes checked by a monitor whenever done or error pulses.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 200;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // kind: 0 = acknowledged, 1 = missing ACK, 2 = silent device (timeout)
  typedef struct packed { logic [7:0] d; logic [1:0] kind; } exp_t;
  exp_t       exp_q[$];
  logic [9:0] obs_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired, got timeout, required event", name);
  endtask

  // Frame as it should appear on the wire: data LSB first, odd parity, stop = 1.
  function automatic logic [9:0] wire_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0);
    return {1'b1, par, d};
  endfunction

  // Monitor / scoreboard
  int   inh_cnt = 0, st_cnt = 0, since = 0, oe_hi_chg = 0;
  logic prev_clk_oe = 1'b0, prev_data_oe = 1'b0, prev_pulse = 1'b0;
  always @(negedge clk) begin : mon
    exp_t       e;
    logic [9:0] obs;
    if (ps2_clk_oe === 1'b1 && prev_clk_oe !== 1'b1) begin
      inh_cnt = 0;
      st_cnt  = 0;
    end
    if (ps2_clk_oe === 1'b1) inh_cnt++;
    if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) st_cnt++;
    if (ps2_data_oe !== prev_data_oe && ps2_clk_line === 1'b1 && ps2_clk_oe === 1'b0 &&
        error !== 1'b1 && reset === 1'b0) oe_hi_chg++;
    if (done === 1'b1 || error === 1'b1) begin
      check("done_error_exclusive", {31'd0, done & error}, 32'd0);
      check("single_cycle_pulse", {31'd0, prev_pulse}, 32'd0);
      check("lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_completion: got done=%0b error=%0b, required none", done, error);
      end else begin
        e = exp_q.pop_front();
        check("outcome_error", {31'd0, error}, {31'd0, e.kind != 2'd0});
        check("inhibit_plus_start_len", inh_cnt, INH + 1);
        check("start_len", st_cnt, 1);
        if (e.kind == 2'd2) begin
          check("timeout_cycles", since, TMO);
        end else if (obs_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL frame_missing: got no frame, required %03h", wire_frame(e.d));
        end else begin
          obs = obs_q.pop_front();
          check("frame_bits", {22'd0, obs}, {22'd0, wire_frame(e.d)});
        end
        $display("[TB] txn data=%02h kind=%0d done=%0b error=%0b", e.d, e.kind, done, error);
      end
    end
    if (ps2_clk_oe === 1'b1) since = 0;
    else                     since++;
    prev_clk_oe  = ps2_clk_oe;
    prev_data_oe = ps2_data_oe;
    prev_pulse   = (done === 1'b1) || (error === 1'b1);
  end

  // Device model. mode: 0 ACK, 1 no ACK, 2 never clocks, 3 stops after five clocks
  task automatic device(input int mode, input int half);
    logic [9:0] cap;
    int w;
    cap = '0;
    w = 0;
    while (ps2_clk_line !== 1'b0 && w < 1000) begin @(posedge clk); w++; end
    if (w >= 1000) begin bound_fail("inhibit_seen"); return; end
    w = 0;
    while (!(ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) && w < 4 * INH) begin
      @(posedge clk); w++;
    end
    if (w >= 4 * INH) begin bound_fail("request_to_send"); return; end
    if (mode == 2) return;
    for (int i = 0; i < 11; i++) begin
      if (i == 10 && mode == 0) dev_data = 1'b0;
      repeat (half) @(posedge clk);
      #1 dev_clk = 1'b0;
      repeat (half) @(posedge clk);
      #1 dev_clk = 1'b1;
      if (i < 10) cap[i] = ps2_data_line;
      if (i == 9) obs_q.push_back(cap);
      if (mode == 3 && i == 4) return;
    end
    repeat (half) @(posedge clk);
    #1 dev_data = 1'b1;
  endtask

  task automatic xfer(input logic [7:0] d, input int mode, input int half, input int spam_at);
    exp_t e;
    int w;
    w = 0;
    while (tx_ready !== 1'b1 && w < 20000) begin @(posedge clk); w++; end
    if (w >= 20000) bound_fail("ready_before_send");
    if (mode != 3) begin
      e.d = d;
      e.kind = mode[1:0];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 tx_data = d; tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0; tx_data = 8'($urandom);
    fork
      device(mode, half);
      if (spam_at > 0) begin
        repeat (spam_at) @(posedge clk);
        #1 tx_data = 8'h00; tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
      end
    join
    if (mode == 3) return;
    w = 0;
    while (busy !== 1'b0 && w < 20000) begin @(posedge clk); w++; end
    if (w >= 20000) bound_fail("transfer_complete");
    repeat (30) @(posedge clk);
    #1 check("idle_after_transfer", {30'd0, tx_ready, ps2_clk_oe}, 32'd2);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] d;
    int r, mode;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b0;

    xfer(8'hF4, 0, 60, 0);
    xfer(8'hED, 1, 60, 0);
    xfer(8'h5A, 2, 60, 0);
    xfer(8'h3C, 0, 50, INH + 30);

    // Abort mid-frame with reset while the device holds bit 4.
    d = 8'hA5;
    xfer(d, 3, 50, 0);
    repeat (3) @(posedge clk);
    #1 check("pre_reset_data_oe", {31'd0, ps2_data_oe}, {31'd0, ~d[4]});
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("abort_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    check("abort_tx_ready", {31'd0, tx_ready}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (200) @(posedge clk);
    #1 check("abort_idle", {31'd0, busy}, 32'd0);

    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom);
      r = $urandom_range(0, 9);
      mode = (r < 7) ? 0 : (r < 9) ? 1 : 2;
      xfer(d, mode, $urandom_range(40, 80),
           ($urandom_range(0, 1) == 1) ? $urandom_range(2, INH + 200) : 0);
    end

    check("data_oe_changed_while_clk_high", oe_hi_chg, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
